// File: rtl/l1a_frame_generator.sv
// Test-pattern source: one event frame (per ADC: header + N_SAMPLES samples) per queued L1A.
// Latency: header valid one edge after pending becomes nonzero; frames back-to-back while queued.
// Backpressure: data_out/data_valid hold while data_ready=0; triggers queue (max 15), excess dropped.
module l1a_frame_generator #(
    parameter int          N_ADC     = 16,
    parameter int          N_SAMPLES = 4,
    parameter logic [13:0] L1A_START = 14'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        l1a_in,
    input  logic        data_ready,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic [3:0]  pending,
    output logic [15:0] frames_sent,
    output logic [15:0] l1a_dropped
);

    localparam logic [3:0] LAST_ADC = 4'(N_ADC - 1);
    localparam logic [9:0] LAST_S   = 10'(N_SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, HEADER, SAMPLES} state_t;

    state_t      state;
    logic [3:0]  adc;
    logic [9:0]  s;
    logic [13:0] next_l1a;

    logic        xfer;
    logic        done;
    logic        drop;
    logic [3:0]  pend_nxt;

    function automatic logic [31:0] hdr_word(input logic [3:0] a, input logic [13:0] l);
        return {2'b11, 10'b0, a, 2'b11, l};
    endfunction

    function automatic logic [31:0] smp_word(input logic [3:0] a, input logic [9:0] n,
                                             input logic [13:0] l);
        return {2'b10, a, n, 2'b00, l};
    endfunction

    assign xfer = data_valid && data_ready;
    assign done = (state == SAMPLES) && xfer && (s == LAST_S) && (adc == LAST_ADC);
    assign busy = (state != IDLE);

    // A trigger landing on the completion edge takes the slot the finished frame frees.
    always_comb begin
        drop     = 1'b0;
        pend_nxt = pending;
        if (l1a_in) begin
            if (done)
                pend_nxt = pending;
            else if (pending != 4'd15)
                pend_nxt = pending + 4'd1;
            else
                drop = 1'b1;
        end else if (done) begin
            pend_nxt = pending - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            adc         <= 4'd0;
            s           <= 10'd0;
            next_l1a    <= L1A_START;
            pending     <= 4'd0;
            frames_sent <= 16'd0;
            l1a_dropped <= 16'd0;
            data_out    <= 32'h0;
            data_valid  <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (drop && l1a_dropped != 16'hFFFF)
                l1a_dropped <= l1a_dropped + 16'd1;

            case (state)
                IDLE: begin
                    if (pending != 4'd0 && enable) begin
                        state      <= HEADER;
                        adc        <= 4'd0;
                        data_out   <= hdr_word(4'd0, next_l1a);
                        data_valid <= 1'b1;
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        state    <= SAMPLES;
                        s        <= 10'd0;
                        data_out <= smp_word(adc, 10'd0, next_l1a);
                    end
                end
                SAMPLES: begin
                    if (xfer) begin
                        if (s != LAST_S) begin
                            s        <= s + 10'd1;
                            data_out <= smp_word(adc, s + 10'd1, next_l1a);
                        end else if (adc != LAST_ADC) begin
                            adc      <= adc + 4'd1;
                            state    <= HEADER;
                            data_out <= hdr_word(adc + 4'd1, next_l1a);
                        end else begin
                            frames_sent <= frames_sent + 16'd1;
                            next_l1a    <= next_l1a + 14'd1;
                            if (pend_nxt != 4'd0 && enable) begin
                                state      <= HEADER;
                                adc        <= 4'd0;
                                data_out   <= hdr_word(4'd0, next_l1a + 14'd1);
                                data_valid <= 1'b1;
                            end else begin
                                state      <= IDLE;
                                data_out   <= 32'h0;
                                data_valid <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    data_out   <= 32'h0;
                    data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1a_frame_generator.sv
// Scoreboard bench for l1a_frame_generator: stimulus pushes expected words, monitors pop and compare.
module tb_l1a_frame_generator;

    localparam int NA = 16;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        l1a_in = 1'b0;
    logic        l1a_in2 = 1'b0;
    logic        data_ready;
    logic        rnd_mode = 1'b0;

    logic [31:0] data_out, data_out2;
    logic        data_valid, data_valid2, busy, busy2;
    logic [3:0]  pending, pending2;
    logic [15:0] frames_sent, frames_sent2, l1a_dropped, l1a_dropped2;

    int checks = 0;
    int failures = 0;
    int xfer_cnt = 0;
    int base;
    logic [31:0] exp[$];
    logic [31:0] exp2[$];
    logic [31:0] rx[$];
    logic [31:0] rx2[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat = 32'h0;

    always #5 clk = ~clk;

    l1a_frame_generator #(.N_ADC(NA), .N_SAMPLES(NS), .L1A_START(14'd1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .l1a_in(l1a_in), .data_ready(data_ready),
        .data_out(data_out), .data_valid(data_valid), .busy(busy), .pending(pending),
        .frames_sent(frames_sent), .l1a_dropped(l1a_dropped));

    l1a_frame_generator #(.N_ADC(NA), .N_SAMPLES(NS), .L1A_START(14'h3FFF)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .l1a_in(l1a_in2), .data_ready(data_ready),
        .data_out(data_out2), .data_valid(data_valid2), .busy(busy2), .pending(pending2),
        .frames_sent(frames_sent2), .l1a_dropped(l1a_dropped2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_frame(input int l);
        for (int a = 0; a < NA; a++) begin
            exp.push_back(32'hC000_C000 | (a << 16) | l);
            for (int n = 0; n < NS; n++)
                exp.push_back(32'h8000_0000 | (a << 26) | (n << 16) | l);
        end
    endtask

    task automatic push_frame2(input int l);
        for (int a = 0; a < NA; a++) begin
            exp2.push_back(32'hC000_C000 | (a << 16) | l);
            for (int n = 0; n < NS; n++)
                exp2.push_back(32'h8000_0000 | (a << 26) | (n << 16) | l);
        end
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            l1a_in = 1'b1;
            @(posedge clk); #1;
        end
        l1a_in = 1'b0;
    endtask

    task automatic timeout_chk(input string name, input bit expired);
        checks++;
        if (expired) begin
            failures++;
            $display("FAIL %s: timed out waiting, required event never came", name);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (!(frames_sent == 16'(n) && !busy) && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        timeout_chk("wait_frames", c >= budget);
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int c = 0;
        while (xfer_cnt < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        timeout_chk("wait_xfers", c >= budget);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // data_ready driver: constant 1 or pseudo-random toggling
    initial begin
        data_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            data_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor for main instance: scoreboard, stall stability, idle-zero
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (prev_stall) begin
                    chk("stall_valid_hold", 32'(data_valid), 32'd1);
                    chk("stall_data_hold", data_out, prev_dat);
                end
                if (!data_valid)
                    chk("idle_data_zero", data_out, 32'h0);
                if (data_valid && data_ready) begin
                    rx.push_back(data_out);
                    xfer_cnt++;
                    if (exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL word: got %h expected none (unexpected word)", data_out);
                    end else begin
                        chk("word", data_out, exp.pop_front());
                    end
                end
                prev_stall = data_valid && !data_ready;
                prev_dat   = data_out;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // monitor for the L1A_START=3FFF instance
    initial begin
        forever begin
            @(negedge clk);
            if (reset && data_valid2 && data_ready) begin
                rx2.push_back(data_out2);
                if (exp2.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL word2: got %h expected none (unexpected word)", data_out2);
                end else begin
                    chk("word2", data_out2, exp2.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_frames", 32'(frames_sent), 32'd0);
        chk("rst_dropped", 32'(l1a_dropped), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // test 1: single trigger, latency and word constants
        base = rx.size();
        push_frame(1);
        l1a_in = 1'b1;
        @(posedge clk); #1;
        l1a_in = 1'b0;
        chk("t1_pending_after_t", 32'(pending), 32'd1);
        chk("t1_valid_after_t", 32'(data_valid), 32'd0);
        @(posedge clk); #1;
        chk("t1_valid_after_t1", 32'(data_valid), 32'd1);
        chk("t1_first_header", data_out, 32'hC000_C001);
        wait_frames(1, 400);
        chk("t1_words", 32'(rx.size() - base), 32'd80);
        chk("t1_word0", rx[base], 32'hC000_C001);
        chk("t1_word1", rx[base + 1], 32'h8000_0001);
        chk("t1_word5", rx[base + 5], 32'hC001_C001);
        chk("t1_word79", rx[base + 79], 32'hBC03_0001);
        chk("t1_frames", 32'(frames_sent), 32'd1);
        chk("t1_pending", 32'(pending), 32'd0);

        // test 4: L1A wrap 3FFF -> 0000, back-to-back
        push_frame2(14'h3FFF);
        push_frame2(0);
        l1a_in2 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        l1a_in2 = 1'b0;
        begin
            int c = 0;
            while (frames_sent2 != 16'd1 && c < 400) begin
                @(posedge clk); #1;
                c++;
            end
            timeout_chk("t4_first_frame", c >= 400);
        end
        chk("t4_no_gap_valid", 32'(data_valid2), 32'd1);
        chk("t4_no_gap_header", data_out2, 32'hC000_C000);
        begin
            int c = 0;
            while (!(frames_sent2 == 16'd2 && !busy2) && c < 400) begin
                @(posedge clk); #1;
                c++;
            end
            timeout_chk("t4_second_frame", c >= 400);
        end
        chk("t4_words", 32'(rx2.size()), 32'd160);
        chk("t4_f1_word0", rx2[0], 32'hC000_FFFF);
        chk("t4_f2_word0", rx2[80], 32'hC000_C000);

        // test 2: three frames with random backpressure
        push_frame(2);
        push_frame(3);
        push_frame(4);
        rnd_mode = 1'b1;
        pulse(3);
        wait_frames(4, 3000);
        rnd_mode = 1'b0;
        @(posedge clk); #1;
        chk("t2_frames", 32'(frames_sent), 32'd4);
        chk("t2_drained", 32'(exp.size()), 32'd0);

        // test 3: twenty consecutive triggers from reset
        do_reset();
        for (int l = 1; l <= 15; l++) push_frame(l);
        pulse(20);
        chk("t3_pending_full", 32'(pending), 32'd15);
        chk("t3_dropped", 32'(l1a_dropped), 32'd5);
        wait_frames(15, 5000);
        chk("t3_frames", 32'(frames_sent), 32'd15);
        chk("t3_pending_end", 32'(pending), 32'd0);
        chk("t3_drained", 32'(exp.size()), 32'd0);

        // test 5: reset in the middle of frame 1
        do_reset();
        push_frame(1);
        base = xfer_cnt;
        pulse(1);
        wait_xfers(base + 40, 400);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp.delete();
        chk("t5_data_out", data_out, 32'h0);
        chk("t5_valid", 32'(data_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_pending", 32'(pending), 32'd0);
        chk("t5_frames", 32'(frames_sent), 32'd0);
        chk("t5_dropped", 32'(l1a_dropped), 32'd0);
        base = rx.size();
        push_frame(1);
        pulse(1);
        wait_frames(1, 400);
        chk("t5_restart_word0", rx[base], 32'hC000_C001);

        // test 6a: trigger on the completion edge with pending=1
        push_frame(2);
        push_frame(3);
        base = xfer_cnt;
        pulse(1);
        begin
            int c = 0;
            while (xfer_cnt < base + 80 && c < 400) begin
                @(negedge clk); #1;
                c++;
            end
            timeout_chk("t6a_last_word", c >= 400);
        end
        l1a_in = 1'b1;
        @(posedge clk); #1;
        l1a_in = 1'b0;
        chk("t6a_pending", 32'(pending), 32'd1);
        chk("t6a_frames", 32'(frames_sent), 32'd2);
        chk("t6a_b2b_valid", 32'(data_valid), 32'd1);
        chk("t6a_b2b_header", data_out, 32'hC000_C003);
        wait_frames(3, 400);
        chk("t6a_pending_end", 32'(pending), 32'd0);

        // test 6b: enable dropped mid-frame
        push_frame(4);
        base = xfer_cnt;
        pulse(1);
        wait_xfers(base + 40, 400);
        enable = 1'b0;
        pulse(1);
        chk("t6b_pending_mid", 32'(pending), 32'd2);
        wait_frames(4, 400);
        chk("t6b_pending_held", 32'(pending), 32'd1);
        chk("t6b_idle_valid", 32'(data_valid), 32'd0);
        repeat (10) begin @(posedge clk); #1; end
        chk("t6b_still_idle", 32'(busy), 32'd0);
        chk("t6b_still_pending", 32'(pending), 32'd1);
        push_frame(5);
        enable = 1'b1;
        wait_frames(5, 400);
        chk("t6b_pending_end", 32'(pending), 32'd0);
        chk("end_drained", 32'(exp.size()), 32'd0);
        chk("end_drained2", 32'(exp2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
